// File: rtl/uart_pkg.sv
// Shared types and constants for the result-to-ASCII sender.
// States of the sender FSM plus the ASCII codes it emits.
package uart_pkg;

  typedef enum logic [3:0] {
    FLUSH,
    GAP_F,
    IDLE,
    CONV,
    LOAD,
    REQ,
    XMIT,
    GAP,
    DONE_ST
  } state_e;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, DATA_W shifts.
// bcd_valid rises with the final shift and stays high until the next go.
module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [DATA_W-1:0]     bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   sr_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [CW-1:0]       cnt_q;
  logic                valid_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (go) begin
      sr_q    <= bin;
      bcd_q   <= '0;
      cnt_q   <= CW'(DATA_W);
      valid_q <= 1'b0;
    end else if (cnt_q != '0) begin
      bcd_q   <= {adj[4*DIGITS-2:0], sr_q[DATA_W-1]};
      sr_q    <= {sr_q[DATA_W-2:0], 1'b0};
      cnt_q   <= cnt_q - CW'(1);
      valid_q <= (cnt_q == CW'(1));
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;

endmodule

// File: rtl/result_ascii_sender.sv
// Prints an unsigned result as decimal ASCII (+ optional CR LF)
// to the RS232 transmitter over its data/data_ready/rts handshake.
module result_ascii_sender
  import uart_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DIGITS     = 5,
  parameter int GAP_CYCLES = 5210,
  parameter int SEND_CRLF  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        data,
  output logic              data_ready,
  input  logic              rts
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int IW = $clog2(DIGITS + 3);
  localparam int LAST = (SEND_CRLF != 0) ? DIGITS + 1 : DIGITS - 1;
  localparam logic [GW-1:0] GAP_END  = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(LAST);
  localparam logic [IW-1:0] IDX_CR   = IW'(DIGITS);

  state_e              state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       first;
  logic [7:0]          data_q, data_d;
  logic                dr_q, dr_d;
  logic                go;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;
  logic [3:0]          dig;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (go),
    .bin       (value),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  // Leading zeros are skipped by starting at the MS non-zero digit;
  // the LS digit is the fallback so 0 prints as "0".
  always_comb begin
    first = IW'(DIGITS - 1);
    dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0)
        first = IW'(DIGITS - 1 - i);
      if (idx_q == IW'(DIGITS - 1 - i))
        dig = bcd[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dr_d    = dr_q;
    go      = 1'b0;
    unique case (state_q)
      FLUSH: if (rts) state_d = GAP_F;
      GAP_F: begin
        if (gap_q == GAP_END) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      IDLE: begin
        idx_d = '0;
        if (start) begin
          go      = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (bcd_valid) begin
          idx_d   = first;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (idx_q > IDX_LAST) begin
          state_d = DONE_ST;
        end else begin
          dr_d    = 1'b1;
          state_d = REQ;
          if (idx_q < IDX_CR)       data_d = ASCII_0 + {4'h0, dig};
          else if (idx_q == IDX_CR) data_d = ASCII_CR;
          else                      data_d = ASCII_LF;
        end
      end
      REQ: begin
        if (!rts) begin
          dr_d    = 1'b0;
          state_d = XMIT;
        end
      end
      XMIT: if (rts) state_d = GAP;
      GAP: begin
        if (gap_q == GAP_END) begin
          gap_d   = '0;
          idx_d   = idx_q + IW'(1);
          state_d = LOAD;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      gap_q   <= '0;
      idx_q   <= '0;
      data_q  <= 8'h00;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dr_q    <= dr_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE_ST);
  assign data       = data_q;
  assign data_ready = dr_q;

endmodule

// File: tb/tb_result_ascii_sender.sv
// Bench: two senders (with / without CR LF), each paired with a
// behavioural RS232 TX; received bytes are scored against a queue.
module tb_result_ascii_sender;

  localparam int GAP = 8;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] value0 = '0, value1 = '0;
  logic        busy0, busy1, done0, done1, dr0, dr1, rts0, rts1;
  logic [7:0]  data0, data1;

  logic [8:0]  rx_q[$];
  logic [8:0]  exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  result_ascii_sender #(
    .DATA_W(16), .DIGITS(5), .GAP_CYCLES(GAP), .SEND_CRLF(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .value(value0), .start(start0),
    .busy(busy0), .done(done0), .data(data0),
    .data_ready(dr0), .rts(rts0)
  );

  result_ascii_sender #(
    .DATA_W(16), .DIGITS(5), .GAP_CYCLES(GAP), .SEND_CRLF(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .value(value1), .start(start1),
    .busy(busy1), .done(done1), .data(data1),
    .data_ready(dr1), .rts(rts1)
  );

  // TX model: no reset; start bit + 8 data bits with rts low,
  // then a stop bit with rts high; reads data bits live.
  for (genvar c = 0; c < 2; c++) begin : g_tx
    logic       rts_g = 1'b1;
    logic       act = 1'b0;
    int         cyc = 0;
    logic [7:0] sh = '0;
    logic       dr_c;
    logic [7:0] d_c;
    if (c == 0) begin : g_c0
      assign rts0 = rts_g;
      assign dr_c = dr0;
      assign d_c  = data0;
    end else begin : g_c1
      assign rts1 = rts_g;
      assign dr_c = dr1;
      assign d_c  = data1;
    end
    always @(posedge clk) begin
      if (!act) begin
        if (dr_c) begin
          act = 1'b1;
          cyc = 0;
          rts_g <= 1'b0;
        end
      end else begin
        cyc++;
        if (cyc >= DIV && cyc < 9*DIV && (cyc % DIV) == DIV/2)
          sh[cyc/DIV - 1] = d_c[cyc/DIV - 1];
        if (cyc == 9*DIV) rts_g <= 1'b1;
        if (cyc == 10*DIV) begin
          act = 1'b0;
          rx_q.push_back({c == 1, sh});
        end
      end
    end
  end

  task automatic push_exp(input int ch, input int v, input bit crlf);
    int d[$];
    int x;
    x = v;
    do begin
      d.push_front(x % 10);
      x = x / 10;
    end while (x > 0);
    foreach (d[i]) exp_q.push_back({ch == 1, 8'(8'h30 + d[i])});
    if (crlf) begin
      exp_q.push_back({ch == 1, 8'h0D});
      exp_q.push_back({ch == 1, 8'h0A});
    end
  endtask

  task automatic do_start(input int ch, input int v, input bit expect_it);
    @(negedge clk);
    if (ch == 0) begin start0 = 1'b1; value0 = 16'(v); end
    else         begin start1 = 1'b1; value1 = 16'(v); end
    if (expect_it) push_exp(ch, v, ch == 0);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    value0 = 16'($urandom);
    value1 = 16'($urandom);
  endtask

  task automatic wait_idle(input int ch, output int nd, output bit to);
    nd = 0;
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if ((ch == 0) ? done0 : done1) nd++;
      if (!((ch == 0) ? busy0 : busy1)) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    #2;
    n_chk++;
    if (busy0 !== 1'b1 || dr0 !== 1'b0 || done0 !== 1'b0 || data0 !== 8'h00)
      $display("FAIL reset_state busy=%b dr=%b done=%b data=%h want 1 0 0 00",
               busy0, dr0, done0, data0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_chk++;
    if (n < GAP || n > GAP + 3)
      $display("FAIL reset_flush_gap got %0d cycles want %0d..%0d", n, GAP, GAP + 3);
    else n_pass++;
    n = 0;
    while (busy1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_chk++;
    if (busy1 !== 1'b0 || done0 !== 1'b0)
      $display("FAIL reset_idle busy1=%b done0=%b want 0 0", busy1, done0);
    else n_pass++;
  endtask

  task automatic test_value(input int ch, input int v);
    int lat, nd, idx;
    bit to;
    logic [8:0] e, a;
    rx_q.delete();
    exp_q.delete();
    do_start(ch, v, 1'b1);
    lat = 0;
    while (!((ch == 0) ? dr0 : dr1) && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    n_chk++;
    if (lat !== 18) $display("FAIL latency v=%0d got %0d want 18", v, lat);
    else n_pass++;
    wait_idle(ch, nd, to);
    n_chk++;
    if (to || nd !== 1)
      $display("FAIL done_pulse v=%0d got %0d timeout=%b want 1 0", v, nd, to);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (((ch == 0) ? busy0 : busy1) !== 1'b0)
      $display("FAIL busy_after v=%0d got 1 want 0", v);
    else n_pass++;
    n_chk++;
    if (rx_q.size() !== exp_q.size())
      $display("FAIL byte_count v=%0d got %0d want %0d", v, rx_q.size(), exp_q.size());
    else n_pass++;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
      n_chk++;
      if (a !== e) $display("FAIL stream v=%0d byte%0d got %h want %h", v, idx, a, e);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_busy_ignore();
    int nd, k, idx;
    bit to;
    logic [8:0] e, a;
    rx_q.delete();
    exp_q.delete();
    do_start(0, 321, 1'b1);
    repeat (3) @(negedge clk);
    do_start(0, 7, 1'b0);
    k = 0;
    while (!dr0 && k < 100) begin
      k++;
      @(negedge clk);
    end
    do_start(0, 7, 1'b0);
    wait_idle(0, nd, to);
    n_chk++;
    if (to || nd !== 1) $display("FAIL ignore_done got %0d timeout=%b want 1 0", nd, to);
    else n_pass++;
    repeat (30) @(negedge clk);
    n_chk++;
    if (rx_q.size() !== exp_q.size() || busy0 !== 1'b0)
      $display("FAIL ignore_count got %0d busy=%b want %0d 0", rx_q.size(), busy0, exp_q.size());
    else n_pass++;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
      n_chk++;
      if (a !== e) $display("FAIL ignore_stream byte%0d got %h want %h", idx, a, e);
      else n_pass++;
      idx++;
    end
  endtask

  task automatic test_reset_midbyte();
    int k, n, nd, idx;
    bit to, leak;
    logic [8:0] e, a;
    rx_q.delete();
    exp_q.delete();
    do_start(0, 12345, 1'b0);
    k = 0;
    while (rx_q.size() < 2 && k < 5000) begin
      k++;
      @(negedge clk);
    end
    while (rts0 && k < 6000) begin
      k++;
      @(negedge clk);
    end
    n_chk++;
    if (k >= 5000) $display("FAIL midbyte_reach got timeout want 3rd byte");
    else n_pass++;
    repeat (4*DIV) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (dr0 !== 1'b0 || busy0 !== 1'b1 || data0 !== 8'h00)
      $display("FAIL midbyte_reset dr=%b busy=%b data=%h want 0 1 00", dr0, busy0, data0);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    leak = 1'b0;
    k = 0;
    while (!rts0 && k < 500) begin
      if (dr0 || !busy0) leak = 1'b1;
      k++;
      @(negedge clk);
    end
    n_chk++;
    if (leak || k >= 500) $display("FAIL midbyte_flush leak=%b timeout=%b want 0 0", leak, k >= 500);
    else n_pass++;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_chk++;
    if (n < GAP || n > GAP + 2)
      $display("FAIL midbyte_gap got %0d cycles want %0d..%0d", n, GAP, GAP + 2);
    else n_pass++;
    rx_q.delete();
    exp_q.delete();
    do_start(0, 42, 1'b1);
    wait_idle(0, nd, to);
    n_chk++;
    if (to || nd !== 1 || rx_q.size() !== exp_q.size())
      $display("FAIL after_reset got done=%0d bytes=%0d want 1 %0d", nd, rx_q.size(), exp_q.size());
    else n_pass++;
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 9'h1FF;
      n_chk++;
      if (a !== e) $display("FAIL after_reset_stream byte%0d got %h want %h", idx, a, e);
      else n_pass++;
      idx++;
    end
  endtask

  initial begin
    test_reset();
    test_value(0, 12345);
    test_value(0, 0);
    test_value(0, 100);
    test_value(1, 65535);
    test_busy_ignore();
    test_reset_midbyte();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
